dcache_dm: RTL and testbench

Parametrised direct-mapped, write-through, no-write-allocate data cache for the core's memory-access stage. It replaces the unimplemented single-port data-cache stub. New capabilities:
- request/ready handshake on the core side;
- line refill over a word-wide memory bus;
- byte/half/word loads with sign or zero extension, and byte-strobed stores;
- misalignment fault reporting;
- single-cycle flush.

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_align.sv | 57 +++++
 rtl/dcache_dm.sv | 218 +++++++++++++++++++++
 tb/tb_dcache_dm.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared encodings, state enum and address-split helpers for the data cache
package dcache_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Byte offset inside a line: 2 bits of byte-in-word plus the word select.
  function automatic int unsigned off_bits(input int unsigned line_words);
    return 2 + $clog2(line_words);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned xlen, input int unsigned sets,
                                           input int unsigned line_words);
    return xlen - off_bits(line_words) - idx_bits(sets);
  endfunction

endpackage

// File: rtl/dcache_align.sv
// rtl/dcache_align.sv - load lane extract/extend, store strobe/replicate and misalignment detect
module dcache_align
  import dcache_pkg::*;
(
  input  logic [1:0]  width_i,
  input  logic        unsgn_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] ldata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic        fault_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed byte and half out of the raw word.
  always_comb begin
    byte_v = rword_i[7:0];
    case (lane_i)
      2'd1:    byte_v = rword_i[15:8];
      2'd2:    byte_v = rword_i[23:16];
      2'd3:    byte_v = rword_i[31:24];
      default: byte_v = rword_i[7:0];
    endcase
    half_v = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  // Extend loads, build store lanes/strobes and flag illegal alignments.
  always_comb begin
    ldata_o = rword_i;
    wstrb_o = 4'b0000;
    wdata_o = sdata_i;
    fault_o = 1'b0;
    case (width_i)
      W_BYTE: begin
        ldata_o = {{24{~unsgn_i & byte_v[7]}}, byte_v};
        wstrb_o = 4'b0001 << lane_i;
        wdata_o = {4{sdata_i[7:0]}};
      end
      W_HALF: begin
        ldata_o = {{16{~unsgn_i & half_v[15]}}, half_v};
        wstrb_o = 4'b0011 << lane_i;
        wdata_o = {2{sdata_i[15:0]}};
        fault_o = lane_i[0];
      end
      W_WORD: begin
        wstrb_o = 4'b1111;
        fault_o = (lane_i != 2'b00);
      end
      default: fault_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-through no-write-allocate data cache
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            w_ena,
  input  logic [XLEN-1:0] addr,
  input  logic [1:0]      width,
  input  logic            unsgn,
  input  logic [XLEN-1:0] data_in,
  input  logic            flush,
  output logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] data_out,
  output logic            fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned OFF_W  = off_bits(LINE_WORDS);
  localparam int unsigned IDX_W  = idx_bits(SETS);
  localparam int unsigned TAG_W  = tag_bits(XLEN, SETS, LINE_WORDS);
  localparam int unsigned WSEL_W = $clog2(LINE_WORDS);

  if (XLEN != 32 || SETS < 2 || LINE_WORDS < 2 ||
      (SETS & (SETS - 1)) != 0 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_param_check
    $error("dcache_dm: unsupported XLEN/SETS/LINE_WORDS");
  end

  state_e            state_q, state_d;
  logic [WSEL_W-1:0] beat_q;
  logic [XLEN-1:0]   addr_q;
  logic [1:0]        width_q;
  logic              unsgn_q;
  logic              hit_q;
  logic [XLEN-1:0]   wdata_q;
  logic [3:0]        wstrb_q;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   data_out_q, data_out_d;
  logic              rst_done_q;
  logic [SETS-1:0]   line_valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [XLEN-1:0]   data_q [SETS][LINE_WORDS];

  logic              idle;
  logic [XLEN-1:0]   sel_addr;
  logic [1:0]        sel_width;
  logic              sel_unsgn;
  logic [IDX_W-1:0]  sel_idx;
  logic [TAG_W-1:0]  sel_tag;
  logic [WSEL_W-1:0] sel_wsel;
  logic [XLEN-1:0]   sel_word;
  logic              hit, accept, last_beat, refill_ack, write_ack;
  logic [XLEN-1:0]   ld_data, st_wdata;
  logic [3:0]        st_strb;
  logic              mis;

  // In IDLE the live request drives lookup; afterwards the latched request does.
  assign idle       = (state_q == S_IDLE);
  assign sel_addr   = idle ? addr  : addr_q;
  assign sel_width  = idle ? width : width_q;
  assign sel_unsgn  = idle ? unsgn : unsgn_q;
  assign sel_idx    = sel_addr[OFF_W +: IDX_W];
  assign sel_tag    = sel_addr[XLEN-1 -: TAG_W];
  assign sel_wsel   = sel_addr[2 +: WSEL_W];
  assign last_beat  = (beat_q == WSEL_W'(LINE_WORDS - 1));
  assign refill_ack = (state_q == S_REFILL) && mem_ack;
  assign write_ack  = (state_q == S_WRITE) && mem_ack;
  assign hit        = line_valid_q[sel_idx] && (tag_q[sel_idx] == sel_tag);

  // The final refill beat is not in the array yet, so bypass it from the bus.
  assign sel_word = ((state_q == S_REFILL) && (beat_q == sel_wsel)) ? mem_rdata
                                                                     : data_q[sel_idx][sel_wsel];

  assign ready  = rst_done_q && idle && !flush;
  assign accept = ready && req;

  dcache_align u_align (
    .width_i (sel_width),
    .unsgn_i (sel_unsgn),
    .lane_i  (sel_addr[1:0]),
    .rword_i (sel_word),
    .sdata_i (data_in),
    .ldata_o (ld_data),
    .wstrb_o (st_strb),
    .wdata_o (st_wdata),
    .fault_o (mis)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state plus the response pulse and load result for the next cycle.
  always_comb begin
    state_d    = state_q;
    valid_d    = 1'b0;
    fault_d    = 1'b0;
    data_out_d = data_out_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (mis) begin
            valid_d = 1'b1;
            fault_d = 1'b1;
          end else if (w_ena) begin
            state_d = S_WRITE;
          end else if (hit) begin
            valid_d    = 1'b1;
            data_out_d = ld_data;
          end else begin
            state_d = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        if (mem_ack && last_beat) begin
          state_d    = S_RESP;
          valid_d    = 1'b1;
          data_out_d = ld_data;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          state_d = S_RESP;
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, beat counter, valid bits and the registered core response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_done_q   <= 1'b0;
      beat_q       <= '0;
      addr_q       <= '0;
      width_q      <= 2'b00;
      unsgn_q      <= 1'b0;
      hit_q        <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= 4'b0000;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      data_out_q   <= '0;
      line_valid_q <= '0;
    end else begin
      rst_done_q <= 1'b1;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      data_out_q <= data_out_d;
      if (accept) begin
        addr_q  <= addr;
        width_q <= width;
        unsgn_q <= unsgn;
        hit_q   <= hit;
        wdata_q <= st_wdata;
        wstrb_q <= st_strb;
        beat_q  <= '0;
      end
      if (refill_ack) beat_q <= beat_q + 1'b1;
      if (idle && flush) line_valid_q <= '0;
      else if (refill_ack && last_beat) line_valid_q[sel_idx] <= 1'b1;
    end
  end

  // Tag/data arrays: refill beats, and write-through merge on a store hit.
  always_ff @(posedge clk) begin
    if (refill_ack) begin
      data_q[sel_idx][beat_q] <= mem_rdata;
      if (last_beat) tag_q[sel_idx] <= sel_tag;
    end
    if (write_ack && hit_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) data_q[sel_idx][sel_wsel][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign valid    = valid_q;
  assign fault    = fault_q;
  assign data_out = data_out_q;

  // Memory bus is decoded from state so reset drops it immediately.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = 4'b0000;
    if (state_q == S_REFILL) begin
      mem_req  = 1'b1;
      mem_addr = {addr_q[XLEN-1:OFF_W], beat_q, 2'b00};
    end else if (state_q == S_WRITE) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {addr_q[XLEN-1:2], 2'b00};
      mem_wdata = wdata_q;
      mem_wstrb = wstrb_q;
    end
  end

endmodule

// File: tb/tb_dcache_dm.sv
// tb/tb_dcache_dm.sv - directed self-checking bench for dcache_dm
module tb_dcache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, w_ena, unsgn, flush;
  logic [31:0] addr, data_in;
  logic [1:0]  width;
  logic        ready, valid, fault;
  logic [31:0] data_out;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  dcache_dm #(.XLEN(32), .SETS(64), .LINE_WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .w_ena     (w_ena),
    .addr      (addr),
    .width     (width),
    .unsgn     (unsgn),
    .data_in   (data_in),
    .flush     (flush),
    .ready     (ready),
    .valid     (valid),
    .data_out  (data_out),
    .fault     (fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model: acks one cycle after it first sees a request, logs traffic.
  logic [31:0] mem [0:1023];
  logic [31:0] rd_log [$];
  int          wr_cnt = 0;
  logic [31:0] last_wr_addr, last_wr_data;
  logic [3:0]  last_wr_strb;
  logic        seen;

  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    seen = 1'b0;
    last_wr_addr = '0;
    last_wr_data = '0;
    last_wr_strb = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem[64 + i] = 32'h11111111 * (i + 1);
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        mem_ack = 1'b0;
        seen = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req === 1'b1) begin
        if (seen) begin
          mem_ack = 1'b1;
          seen = 1'b0;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            wr_cnt++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
            last_wr_strb = mem_wstrb;
          end else begin
            mem_rdata = mem[mem_addr[11:2]];
            rd_log.push_back(mem_addr);
          end
        end else begin
          seen = 1'b1;
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  int reqcyc = 0;
  always @(negedge clk) if (mem_req === 1'b1) reqcyc++;

  logic [31:0] dout;
  logic        f;
  int          lat, n0, r0, w0, g;

  task automatic access(input logic we, input logic [31:0] a, input logic [1:0] w,
                        input logic u, input logic [31:0] d,
                        output logic [31:0] o_data, output logic o_fault, output int o_lat);
    int guard;
    @(negedge clk);
    req = 1'b1; w_ena = we; addr = a; width = w; unsgn = u; data_in = d;
    guard = 0;
    while (ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("accept_ready", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1 req = 1'b0;
    o_lat = 0;
    while (o_lat < 200) begin
      @(negedge clk);
      o_lat++;
      if (valid === 1'b1) break;
    end
    check_eq("valid_seen", {31'd0, valid}, 32'd1);
    o_data  = data_out;
    o_fault = fault;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; req = 1'b0; w_ena = 1'b0; addr = '0; width = 2'b00;
    unsgn = 1'b0; data_in = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready",    {31'd0, ready},   32'd0);
    check_eq("rst_valid",    {31'd0, valid},   32'd0);
    check_eq("rst_fault",    {31'd0, fault},   32'd0);
    check_eq("rst_data_out", data_out,         32'd0);
    check_eq("rst_mem_req",  {31'd0, mem_req}, 32'd0);
    check_eq("rst_mem_we",   {31'd0, mem_we},  32'd0);
    check_eq("rst_mem_addr", mem_addr,         32'd0);
    check_eq("rst_mem_wdata", mem_wdata,       32'd0);
    check_eq("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    rst = 1'b1;
    #1 check_eq("ready_before_clk", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1 check_eq("ready_after_rel", {31'd0, ready}, 32'd1);

    // Cold miss refills the whole line in order.
    n0 = rd_log.size();
    access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, dout, f, lat);
    check_eq("lw100_data", dout, 32'h11111111);
    check_eq("lw100_fault", {31'd0, f}, 32'd0);
    check_eq("lw100_beats", rd_log.size() - n0, 32'd4);
    for (int i = 0; i < 4; i++)
      if (rd_log.size() >= n0 + 4) check_eq("lw100_beat_addr", rd_log[n0 + i], 32'h100 + 4 * i);
    r0 = reqcyc;
    access(1'b0, 32'h104, 2'b10, 1'b0, 32'h0, dout, f, lat);
    check_eq("lw104_data", dout, 32'h22222222);
    check_eq("lw104_lat", lat, 32'd1);
    check_eq("lw104_no_mem", reqcyc - r0, 32'd0);

    // Word store hit, then sub-word loads with extension.
    access(1'b1, 32'h100, 2'b10, 1'b0, 32'h000080F0, dout, f, lat);
    check_eq("sw100_addr", last_wr_addr, 32'h100);
    check_eq("sw100_strb", {28'd0, last_wr_strb}, 32'hF);
    check_eq("sw100_wdata", last_wr_data, 32'h000080F0);
    check_eq("sw100_fault", {31'd0, f}, 32'd0);
    access(1'b0, 32'h101, 2'b00, 1'b0, 32'h0, dout, f, lat);
    check_eq("lb101", dout, 32'hFFFFFF80);
    check_eq("lb101_lat", lat, 32'd1);
    access(1'b0, 32'h101, 2'b00, 1'b1, 32'h0, dout, f, lat);
    check_eq("lbu101", dout, 32'h00000080);
    access(1'b0, 32'h100, 2'b01, 1'b0, 32'h0, dout, f, lat);
    check_eq("lh100", dout, 32'hFFFF80F0);

    // Byte store hit merges; store miss does not allocate.
    access(1'b1, 32'h102, 2'b00, 1'b0, 32'h000000A5, dout, f, lat);
    check_eq("sb102_strb", {28'd0, last_wr_strb}, 32'h4);
    check_eq("sb102_wdata", last_wr_data, 32'hA5A5A5A5);
    check_eq("sb102_addr", last_wr_addr, 32'h100);
    r0 = reqcyc;
    access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, dout, f, lat);
    check_eq("lw100_merged", dout, 32'h00A580F0);
    check_eq("lw100_merged_lat", lat, 32'd1);
    check_eq("lw100_merged_no_mem", reqcyc - r0, 32'd0);
    n0 = rd_log.size();
    w0 = wr_cnt;
    access(1'b1, 32'h400, 2'b10, 1'b0, 32'hDEADBEEF, dout, f, lat);
    check_eq("sw400_addr", last_wr_addr, 32'h400);
    check_eq("sw400_strb", {28'd0, last_wr_strb}, 32'hF);
    check_eq("sw400_writes", wr_cnt - w0, 32'd1);
    check_eq("sw400_no_reads", rd_log.size() - n0, 32'd0);
    access(1'b0, 32'h400, 2'b10, 1'b0, 32'h0, dout, f, lat);
    check_eq("lw400_data", dout, 32'hDEADBEEF);
    check_eq("lw400_beats", rd_log.size() - n0, 32'd4);

    // Misaligned and reserved-width accesses fault without touching memory.
    r0 = reqcyc;
    access(1'b0, 32'h102, 2'b10, 1'b0, 32'h0, dout, f, lat);
    check_eq("lw102_fault", {31'd0, f}, 32'd1);
    check_eq("lw102_lat", lat, 32'd1);
    access(1'b0, 32'h103, 2'b01, 1'b0, 32'h0, dout, f, lat);
    check_eq("lh103_fault", {31'd0, f}, 32'd1);
    access(1'b0, 32'h100, 2'b11, 1'b0, 32'h0, dout, f, lat);
    check_eq("w11_fault", {31'd0, f}, 32'd1);
    check_eq("fault_no_mem", reqcyc - r0, 32'd0);

    // Flush together with req: not accepted; the later load misses.
    @(negedge clk);
    req = 1'b1; w_ena = 1'b0; addr = 32'h100; width = 2'b10; unsgn = 1'b0; flush = 1'b1;
    #1 check_eq("flush_ready", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1 check_eq("flush_no_valid", {31'd0, valid}, 32'd0);
    check_eq("flush_no_mem", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    n0 = rd_log.size();
    access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, dout, f, lat);
    check_eq("post_flush_beats", rd_log.size() - n0, 32'd4);
    check_eq("post_flush_data", dout, 32'h00A580F0);

    // Reset in the middle of a refill.
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    req = 1'b1; w_ena = 1'b0; addr = 32'h100; width = 2'b10;
    n0 = rd_log.size();
    @(posedge clk);
    #1 req = 1'b0;
    g = 0;
    while (rd_log.size() - n0 < 2 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_eq("mid_refill_two_beats", rd_log.size() - n0, 32'd2);
    @(posedge clk);
    #1 check_eq("mid_refill_req", {31'd0, mem_req}, 32'd1);
    check_eq("mid_refill_addr", mem_addr, 32'h108);
    rst = 1'b0;
    #1 check_eq("rst_drops_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_drops_ready", {31'd0, ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n0 = rd_log.size();
    access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, dout, f, lat);
    check_eq("after_rst_beats", rd_log.size() - n0, 32'd4);
    if (rd_log.size() >= n0 + 4) check_eq("after_rst_first", rd_log[n0], 32'h100);
    check_eq("after_rst_data", dout, 32'h00A580F0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
